// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// mul_div_unit : iterative RV32M multiply/divide, one radix-2 step per cycle.
// Divider datapath is built only when MUL_DIV_UNIT_DIVIDE_EN is defined.
// Revision: 1.0
// ============================================================================
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [2:0]       func,
   input  logic             inValid,
   output logic             inReady,
   input  logic             flush,
   output logic [WIDTH-1:0] result,
   output logic             outValid,
   input  logic             outReady,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_opnd;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_neg;
   logic             r_low;

   logic             w_a_signed, w_b_signed, w_a_neg, w_b_neg;
   logic [WIDTH-1:0] w_a_mag, w_b_mag;
   logic             w_special;
   logic [WIDTH-1:0] w_special_res;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH-1:0] w_hi_next, w_lo_next;
   logic [2*WIDTH-1:0] w_prod, w_prod_s;
   logic [WIDTH-1:0] w_final;

   assign w_a_signed = (func == 3'b001) | (func == 3'b010) | (func == 3'b100) | (func == 3'b110);
   assign w_b_signed = (func == 3'b001) | (func == 3'b100) | (func == 3'b110);
   assign w_a_neg    = w_a_signed & dataA[WIDTH-1];
   assign w_b_neg    = w_b_signed & dataB[WIDTH-1];
   assign w_a_mag    = w_a_neg ? -dataA : dataA;
   assign w_b_mag    = w_b_neg ? -dataB : dataB;

`ifdef MUL_DIV_UNIT_DIVIDE_EN
   logic             r_div, r_rem_sel, r_rem_neg;
   logic             w_div_zero, w_div_ovf;
   logic [WIDTH:0]   w_div_shift, w_div_trial;
   logic [WIDTH-1:0] w_quo, w_rem;

   assign w_div_zero    = (dataB == '0);
   assign w_div_ovf     = ~func[0] & (dataA == {1'b1, {(WIDTH-1){1'b0}}}) & (dataB == '1);
   assign w_special     = func[2] & (w_div_zero | w_div_ovf);
   assign w_special_res = w_div_zero ? (func[1] ? dataA : '1) : (func[1] ? '0 : dataA);
`else
   // Divide opcodes complete immediately with a zero result.
   assign w_special     = func[2];
   assign w_special_res = '0;
`endif

   // r_hi:r_lo is the product accumulator or the remainder:quotient pair.
   always_comb begin
      w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
      w_hi_next = w_mul_sum[WIDTH:1];
      w_lo_next = {w_mul_sum[0], r_lo[WIDTH-1:1]};
`ifdef MUL_DIV_UNIT_DIVIDE_EN
      w_div_shift = {r_hi, r_lo[WIDTH-1]};
      w_div_trial = w_div_shift - {1'b0, r_opnd};
      if (r_div) begin
         w_hi_next = w_div_trial[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_trial[WIDTH-1:0];
         w_lo_next = {r_lo[WIDTH-2:0], ~w_div_trial[WIDTH]};
      end
`endif
   end

   always_comb begin
      w_prod   = {w_hi_next, w_lo_next};
      w_prod_s = r_neg ? -w_prod : w_prod;
`ifdef MUL_DIV_UNIT_DIVIDE_EN
      w_quo   = r_neg ? -w_lo_next : w_lo_next;
      w_rem   = r_rem_neg ? -w_hi_next : w_hi_next;
      w_final = r_div ? (r_rem_sel ? w_rem : w_quo)
                      : (r_low ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH]);
`else
      w_final = r_low ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH];
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_opnd   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_neg    <= 1'b0;
         r_low    <= 1'b0;
`ifdef MUL_DIV_UNIT_DIVIDE_EN
         r_div     <= 1'b0;
         r_rem_sel <= 1'b0;
         r_rem_neg <= 1'b0;
`endif
         result   <= '0;
         outValid <= 1'b0;
         inReady  <= 1'b1;
         busy     <= 1'b0;
      end else if (flush) begin
         r_state  <= IDLE;
         r_count  <= '0;
         outValid <= 1'b0;
         inReady  <= 1'b1;
         busy     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (inValid) begin
                  r_opnd  <= func[2] ? w_b_mag : w_a_mag;
                  r_lo    <= func[2] ? w_a_mag : w_b_mag;
                  r_hi    <= '0;
                  r_neg   <= w_a_neg ^ w_b_neg;
                  r_low   <= (func[1:0] == 2'b00);
`ifdef MUL_DIV_UNIT_DIVIDE_EN
                  r_div     <= func[2];
                  r_rem_sel <= func[1];
                  r_rem_neg <= w_a_neg;
`endif
                  r_count <= '0;
                  inReady <= 1'b0;
                  busy    <= 1'b1;
                  if (w_special) begin
                     r_state  <= DONE;
                     result   <= w_special_res;
                     outValid <= 1'b1;
                  end else begin
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               r_hi    <= w_hi_next;
               r_lo    <= w_lo_next;
               r_count <= r_count + 1'b1;
               if (r_count == CW'(WIDTH-1)) begin
                  r_state  <= DONE;
                  result   <= w_final;
                  outValid <= 1'b1;
               end
            end
            DONE: begin
               if (outReady) begin
                  r_state  <= IDLE;
                  outValid <= 1'b0;
                  inReady  <= 1'b1;
                  busy     <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
